// File: rtl/dlp_bank_sequencer.sv
// Round-robin write sequencer for a shared bank of DLP latch words.
// Generates setup / gate pulse / hold timing per write and a bank-wide preset cycle.
module dlp_bank_sequencer #(
    parameter int NREQ  = 4,
    parameter int NLAT  = 4,
    parameter int WIDTH = 8,
    parameter int SETUP = 1,
    parameter int PULSE = 2,
    parameter int HOLD  = 1
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic [NREQ-1:0]                                   req,
    input  logic [NREQ*((NLAT > 1) ? $clog2(NLAT) : 1)-1:0]   req_sel,
    input  logic [NREQ*WIDTH-1:0]                             req_data,
    output logic [NREQ-1:0]                                   ack,
    input  logic                                              pre_req,
    output logic                                              pre_ack,
    output logic [WIDTH-1:0]                                  lat_d,
    output logic [NLAT-1:0]                                   lat_g,
    output logic [NLAT-1:0]                                   lat_preset,
    output logic                                              busy
);

    localparam int SEL_W = (NLAT > 1) ? $clog2(NLAT) : 1;
    localparam int PTR_W = $clog2(NREQ);

    // Phase counters hold "cycles remaining minus one" and are reloaded on state entry.
    localparam logic [3:0] SETUP_LD = (SETUP > 0) ? 4'(SETUP - 1) : 4'd0;
    localparam logic [3:0] PULSE_LD = (PULSE > 0) ? 4'(PULSE - 1) : 4'd0;
    localparam logic [3:0] HOLD_LD  = (HOLD > 0)  ? 4'(HOLD - 1)  : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_OPEN,
        S_HOLD,
        S_DONE,
        S_PRESET
    } state_t;

    state_t           state_reg, state_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic [PTR_W-1:0] ptr_reg, ptr_next;
    logic [PTR_W-1:0] win_reg, win_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic             pre_reg, pre_next;
    logic [WIDTH-1:0] lat_d_reg, lat_d_next;
    logic [NLAT-1:0]  lat_g_reg, lat_g_next;
    logic [NLAT-1:0]  lat_preset_reg, lat_preset_next;
    logic [NREQ-1:0]  ack_reg, ack_next;
    logic             pre_ack_reg, pre_ack_next;
    logic             busy_reg, busy_next;

    logic [SEL_W-1:0] sel_arr  [NREQ];
    logic [WIDTH-1:0] data_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign sel_arr[gi]  = req_sel[gi*SEL_W +: SEL_W];
            assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin search: first requester at or after the pointer, wrapping.
    logic             grant_found;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W:0]   rr_sum;
    logic [PTR_W-1:0] rr_idx;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = ptr_reg;
        rr_sum      = '0;
        rr_idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            rr_sum = {1'b0, ptr_reg} + (PTR_W+1)'(k);
            if (rr_sum >= (PTR_W+1)'(NREQ)) begin
                rr_sum = rr_sum - (PTR_W+1)'(NREQ);
            end
            rr_idx = rr_sum[PTR_W-1:0];
            if (!grant_found && req[rr_idx]) begin
                grant_found = 1'b1;
                grant_idx   = rr_idx;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        ptr_next        = ptr_reg;
        win_next        = win_reg;
        sel_next        = sel_reg;
        pre_next        = pre_reg;
        lat_d_next      = lat_d_reg;
        lat_g_next      = '0;
        lat_preset_next = '0;
        ack_next        = '0;
        pre_ack_next    = 1'b0;
        busy_next       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (pre_req) begin
                    state_next = S_PRESET;
                    cnt_next   = PULSE_LD;
                    pre_next   = 1'b1;
                end else if (grant_found) begin
                    win_next   = grant_idx;
                    sel_next   = sel_arr[grant_idx];
                    lat_d_next = data_arr[grant_idx];
                    pre_next   = 1'b0;
                    if (SETUP > 0) begin
                        state_next = S_SETUP;
                        cnt_next   = SETUP_LD;
                    end else begin
                        state_next = S_OPEN;
                        cnt_next   = PULSE_LD;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_reg == 4'd0) begin
                    state_next = S_OPEN;
                    cnt_next   = PULSE_LD;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_OPEN: begin
                if (cnt_reg == 4'd0) begin
                    if (HOLD > 0) begin
                        state_next = S_HOLD;
                        cnt_next   = HOLD_LD;
                    end else begin
                        state_next = S_DONE;
                    end
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_HOLD: begin
                if (cnt_reg == 4'd0) begin
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_PRESET: begin
                if (cnt_reg == 4'd0) begin
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                if (!pre_reg) begin
                    if (win_reg == PTR_W'(NREQ - 1)) begin
                        ptr_next = '0;
                    end else begin
                        ptr_next = win_reg + PTR_W'(1);
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Outputs are registered images of the state being entered.
        busy_next = (state_next != S_IDLE);
        if (state_next == S_OPEN && ({1'b0, sel_next} < (SEL_W+1)'(NLAT))) begin
            lat_g_next[sel_next] = 1'b1;
        end
        if (state_next == S_PRESET) begin
            lat_preset_next = '1;
        end
        if (state_next == S_DONE) begin
            if (pre_next) begin
                pre_ack_next = 1'b1;
            end else begin
                ack_next[win_next] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            ptr_reg        <= '0;
            win_reg        <= '0;
            sel_reg        <= '0;
            pre_reg        <= 1'b0;
            lat_d_reg      <= '0;
            lat_g_reg      <= '0;
            lat_preset_reg <= '0;
            ack_reg        <= '0;
            pre_ack_reg    <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            ptr_reg        <= ptr_next;
            win_reg        <= win_next;
            sel_reg        <= sel_next;
            pre_reg        <= pre_next;
            lat_d_reg      <= lat_d_next;
            lat_g_reg      <= lat_g_next;
            lat_preset_reg <= lat_preset_next;
            ack_reg        <= ack_next;
            pre_ack_reg    <= pre_ack_next;
            busy_reg       <= busy_next;
        end
    end

    assign lat_d      = lat_d_reg;
    assign lat_g      = lat_g_reg;
    assign lat_preset = lat_preset_reg;
    assign ack        = ack_reg;
    assign pre_ack    = pre_ack_reg;
    assign busy       = busy_reg;

endmodule
